tensor_arbiter: RTL and testbench
=================================

Name: tensor_arbiter

Overview:
Shares one 4-lane BF16 tensor unit among NUM_REQ requesters (lanes/warps) with round-robin arbitration.
- Accepts one request at a time, launches it with a single-cycle start pulse, waits for the unit's done pulse, and routes the 64-bit result back to the winning requester.
- Rejects illegal op codes locally, because the tensor unit never signals done for them.
- Sits between the per-requester issue logic and the tensor datapath.

Parameters:
NUM_REQ, 4, number of requesters (legal 2..8)
ID_W, $clog2(NUM_REQ), width of the grant index

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request pending; held until accepted
req_ready  out  NUM_REQ  one-hot accept; combinational; only asserted in IDLE
req_op  in  3*NUM_REQ  op per requester: 0 VADD, 1 VSUB, 2 VMUL, 3 FMAC, 4 RELU
req_a  in  64*NUM_REQ  packed 4xBF16 operand A per requester
req_b  in  64*NUM_REQ  packed 4xBF16 operand B
req_acc  in  64*NUM_REQ  packed 4xBF16 accumulator (FMAC)
rsp_valid  out  NUM_REQ  one-hot single-cycle response pulse
rsp_data  out  64  result, valid with rsp_valid
rsp_err  out  1  illegal op, valid with rsp_valid
t_start  out  1  tensor launch pulse
t_op  out  3  tensor op
t_a, t_b, t_acc  out  64 each  tensor operands
t_rd  in  64  tensor result
t_done  in  1  tensor done pulse
busy  out  1  high in ISSUE or WAIT
op_count  out  32  completed legal ops; wraps modulo 2^32

Behaviour:
Reset: clk is the clock; rst_n is asynchronous, active-low. All outputs go to 0. State is IDLE. rr_ptr is 0.

Arbitration:
- Round-robin search starts at index rr_ptr and wraps; the first index with req_valid set wins.
- rr_ptr is set to winner+1 (mod NUM_REQ) on acceptance.

IDLE:
- If any req_valid is set, req_ready[winner]=1 that cycle and the request is accepted.
- The winner's op and operands are registered into t_op/t_a/t_b/t_acc; gid is set to winner.
- Legal op (0..4): go to ISSUE.
- Illegal op (5..7): go to ERR; the tensor unit is not started.

ISSUE:
- t_start=1 for exactly this one cycle.
- Always go to WAIT.

WAIT:
- On t_done: rsp_data<=t_rd, rsp_err<=0, rsp_valid[gid]<=1 (visible the next cycle), op_count++, go to IDLE.
- A t_done arriving in the same cycle as t_start (ISSUE) is ignored.
- No timeout exists.

ERR:
- rsp_valid[gid]<=1, rsp_err<=1, rsp_data<=0, go to IDLE.

Timing:
- rsp_valid is a registered one-cycle pulse; rsp_data and rsp_err hold until the next response.
- Acceptance may occur in the same cycle that rsp_valid is high, since the FSM is already in IDLE.
- t_op/t_a/t_b/t_acc stay stable from ISSUE until the next acceptance.
- t_done seen in IDLE or ERR is dropped and does not change state.
- Minimum throughput: one op per (tensor latency + 3) cycles.
- Requests deasserted before acceptance are simply not seen; no error is raised.

Reset mid-operation:
- Returns to IDLE immediately; in-flight work is lost with no response.
- The tensor unit is reset by the same rst_n.

Decomposition:
- Shared package tensor_pkg: op encodings (OP_VADD..OP_RELU = 0..4), OP_LAST=4, FSM state encodings (IDLE, ISSUE, WAIT, ERR).
- One sub-module: rr_arbiter (NUM_REQ): inputs req vector and ptr; outputs one-hot grant and its index; purely combinational.
- FSM and datapath registers live in tensor_arbiter.

Test Plan:
1. Req0 VADD, a lanes 0x3F80, b lanes 0x4000 -> req_ready[0] in the same cycle, t_start the next cycle, rsp_valid[0] one cycle after t_done with rsp_data=0x4040404040404040, rsp_err=0, op_count=1.
2. All four req_valid held high, each issuing VMUL -> grants in order 0,1,2,3,0; each rsp_valid one-hot matches its grant; no starvation.
3. Req2 op=3'b110 -> rsp_valid[2] two cycles after acceptance, rsp_err=1, rsp_data=0, t_start never pulses, op_count unchanged.
4. FMAC on req1 with a=0x4000, b=0x4000, acc=0x3F80 lanes -> rsp_data lanes 0x40A0. Inject a spurious t_done while in IDLE -> no rsp_valid.
5. Assert rst_n low during WAIT -> all outputs 0, state IDLE. Next request completes normally, starting arbitration at index 0.
6. Drive t_done in the ISSUE cycle from a stub -> ignored. The real t_done two cycles later produces exactly one rsp_valid.

Source files
------------

// File: rtl/tensor_pkg.sv
// Shared op encodings, FSM states and command payload for the tensor arbiter.
package tensor_pkg;

   localparam int unsigned OP_W   = 3;
   localparam int unsigned DATA_W = 64;

   localparam logic [OP_W-1:0] OP_VADD = 3'd0;
   localparam logic [OP_W-1:0] OP_VSUB = 3'd1;
   localparam logic [OP_W-1:0] OP_VMUL = 3'd2;
   localparam logic [OP_W-1:0] OP_FMAC = 3'd3;
   localparam logic [OP_W-1:0] OP_RELU = 3'd4;
   localparam logic [OP_W-1:0] OP_LAST = OP_RELU;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ERR   = 2'd3
   } state_e;

   // Operation launched on the tensor unit.
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] acc;
   } tensor_cmd_t;

   // Ops above OP_LAST never get a done from the tensor unit.
   function automatic logic op_legal(input logic [OP_W-1:0] op);
      return op <= OP_LAST;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i wins.
module rr_arbiter
   import tensor_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    gnt_idx_o,
   output logic               any_o
);

   int unsigned     idx;
   logic [ID_W-1:0] idx_w;

   // Scan from ptr_i upwards with wrap; keep the first hit.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      any_o     = 1'b0;
      idx       = 0;
      idx_w     = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx   = (32'(ptr_i) + i) % NUM_REQ;
         idx_w = ID_W'(idx);
         if (!any_o && req_i[idx_w]) begin
            any_o        = 1'b1;
            gnt_o[idx_w] = 1'b1;
            gnt_idx_o    = idx_w;
         end
      end
   end

endmodule

// File: rtl/tensor_arbiter.sv
// Shares one 4-lane BF16 tensor unit among NUM_REQ requesters, round-robin.
module tensor_arbiter
   import tensor_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [3*NUM_REQ-1:0]    req_op,
   input  logic [64*NUM_REQ-1:0]   req_a,
   input  logic [64*NUM_REQ-1:0]   req_b,
   input  logic [64*NUM_REQ-1:0]   req_acc,
   output logic [NUM_REQ-1:0]      rsp_valid,
   output logic [63:0]             rsp_data,
   output logic                    rsp_err,
   output logic                    t_start,
   output logic [2:0]              t_op,
   output logic [63:0]             t_a,
   output logic [63:0]             t_b,
   output logic [63:0]             t_acc,
   input  logic [63:0]             t_rd,
   input  logic                    t_done,
   output logic                    busy,
   output logic [31:0]             op_count
);

   state_e               state_q, state_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]      gid_q, gid_d;
   tensor_cmd_t          cmd_q, cmd_d;
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
   logic                 rsp_err_q, rsp_err_d;
   logic [31:0]          op_count_q, op_count_d;
   logic [NUM_REQ-1:0]   req_ready_c;

   logic [NUM_REQ-1:0]   gnt;
   logic [ID_W-1:0]      gnt_idx;
   logic                 gnt_any;

   logic [OP_W-1:0]      op_arr  [NUM_REQ];
   logic [DATA_W-1:0]    a_arr   [NUM_REQ];
   logic [DATA_W-1:0]    b_arr   [NUM_REQ];
   logic [DATA_W-1:0]    acc_arr [NUM_REQ];

   // Slice the flat per-requester buses into indexable arrays.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign op_arr[g]  = req_op[3*g +: 3];
      assign a_arr[g]   = req_a[64*g +: 64];
      assign b_arr[g]   = req_b[64*g +: 64];
      assign acc_arr[g] = req_acc[64*g +: 64];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .req_i     (req_valid),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .any_o     (gnt_any)
   );

   // Next-state, acceptance and response logic.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gid_d       = gid_q;
      cmd_d       = cmd_q;
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      op_count_d  = op_count_q;
      req_ready_c = '0;

      unique case (state_q)
         IDLE: begin
            if (gnt_any) begin
               req_ready_c = gnt;
               gid_d       = gnt_idx;
               cmd_d.op    = op_arr[gnt_idx];
               cmd_d.a     = a_arr[gnt_idx];
               cmd_d.b     = b_arr[gnt_idx];
               cmd_d.acc   = acc_arr[gnt_idx];
               rr_ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
               state_d     = op_legal(op_arr[gnt_idx]) ? ISSUE : ERR;
            end
         end
         ISSUE: begin
            // A done in the launch cycle cannot belong to this op.
            state_d = WAIT;
         end
         WAIT: begin
            if (t_done) begin
               rsp_valid_d = NUM_REQ'(1) << gid_q;
               rsp_data_d  = t_rd;
               rsp_err_d   = 1'b0;
               op_count_d  = op_count_q + 32'd1;
               state_d     = IDLE;
            end
         end
         ERR: begin
            rsp_valid_d = NUM_REQ'(1) << gid_q;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         gid_q       <= '0;
         cmd_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         op_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gid_q       <= gid_d;
         cmd_q       <= cmd_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         op_count_q  <= op_count_d;
      end
   end

   // Accept is combinational; held low while reset is asserted.
   assign req_ready = req_ready_c & {NUM_REQ{rst_n}};
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign t_start   = (state_q == ISSUE);
   assign busy      = (state_q == ISSUE) || (state_q == WAIT);
   assign t_op      = cmd_q.op;
   assign t_a       = cmd_q.a;
   assign t_b       = cmd_q.b;
   assign t_acc     = cmd_q.acc;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_tensor_arbiter.sv
// Directed self-checking bench for tensor_arbiter; the tensor unit is a manual stub.
module tb_tensor_arbiter;

   localparam int unsigned N = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [3*N-1:0]    req_op;
   logic [64*N-1:0]   req_a, req_b, req_acc;
   logic [N-1:0]      rsp_valid;
   logic [63:0]       rsp_data;
   logic              rsp_err;
   logic              t_start;
   logic [2:0]        t_op;
   logic [63:0]       t_a, t_b, t_acc, t_rd;
   logic              t_done;
   logic              busy;
   logic [31:0]       op_count;

   int errors = 0;
   int checks = 0;

   tensor_arbiter #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_acc   (req_acc),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .t_start   (t_start),
      .t_op      (t_op),
      .t_a       (t_a),
      .t_b       (t_b),
      .t_acc     (t_acc),
      .t_rd      (t_rd),
      .t_done    (t_done),
      .busy      (busy),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] acc);
      req_op[3*i +: 3]   = op;
      req_a[64*i +: 64]  = a;
      req_b[64*i +: 64]  = b;
      req_acc[64*i +: 64] = acc;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      t_done    = 1'b0;
      t_rd      = '0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      req_op = '0; req_a = '0; req_b = '0; req_acc = '0;
      do_reset();

      // Reset state
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_rsp_data", rsp_data, 64'h0);
      chk("rst_t_start", 64'(t_start), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_op_count", 64'(op_count), 64'h0);

      // 1: VADD 1.0 + 2.0 = 3.0 on requester 0
      set_req(0, 3'd0, {4{16'h3F80}}, {4{16'h4000}}, 64'h0);
      req_valid = 4'b0001;
      #1 chk("t1_ready", 64'(req_ready), 64'h1);
      tick();
      req_valid = '0;
      chk("t1_start", 64'(t_start), 64'h1);
      chk("t1_busy", 64'(busy), 64'h1);
      chk("t1_t_a", t_a, {4{16'h3F80}});
      chk("t1_t_b", t_b, {4{16'h4000}});
      tick();
      chk("t1_start_off", 64'(t_start), 64'h0);
      t_done = 1'b1; t_rd = {4{16'h4040}};
      tick();
      t_done = 1'b0;
      chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
      chk("t1_rsp_data", rsp_data, 64'h4040404040404040);
      chk("t1_rsp_err", 64'(rsp_err), 64'h0);
      chk("t1_op_count", 64'(op_count), 64'd1);
      tick();
      chk("t1_rsp_pulse", 64'(rsp_valid), 64'h0);

      // 2: all four requesters held; grants 0,1,2,3,0
      do_reset();
      for (int i = 0; i < 4; i++)
         set_req(i, 3'd2, {4{16'(16'h1000 + i)}}, {4{16'h3F80}}, 64'h0);
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1 chk($sformatf("t2_ready_%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
         tick();
         chk($sformatf("t2_op_%0d", k), 64'(t_op), 64'd2);
         chk($sformatf("t2_a_%0d", k), t_a, {4{16'(16'h1000 + (k % 4))}});
         tick();
         t_done = 1'b1; t_rd = 64'(64'hA000 + k);
         tick();
         t_done = 1'b0;
         if (k == 4) req_valid = '0;
         chk($sformatf("t2_rsp_valid_%0d", k), 64'(rsp_valid), 64'(4'b0001 << (k % 4)));
         chk($sformatf("t2_rsp_data_%0d", k), rsp_data, 64'(64'hA000 + k));
      end
      chk("t2_op_count", 64'(op_count), 64'd5);

      // 3: illegal op on requester 2 (ptr is 1)
      set_req(2, 3'b110, 64'h1234, 64'h5678, 64'h0);
      req_valid = 4'b0100;
      #1 chk("t3_ready", 64'(req_ready), 64'h4);
      tick();
      req_valid = '0;
      chk("t3_no_start", 64'(t_start), 64'h0);
      chk("t3_not_busy", 64'(busy), 64'h0);
      chk("t3_no_rsp_yet", 64'(rsp_valid), 64'h0);
      tick();
      chk("t3_no_start2", 64'(t_start), 64'h0);
      chk("t3_rsp_valid", 64'(rsp_valid), 64'h4);
      chk("t3_rsp_err", 64'(rsp_err), 64'h1);
      chk("t3_rsp_data", rsp_data, 64'h0);
      chk("t3_op_count", 64'(op_count), 64'd5);

      // 4: FMAC 2*2+1 = 5.0 on requester 1 (ptr is 3, search 3,0,1)
      set_req(1, 3'd3, {4{16'h4000}}, {4{16'h4000}}, {4{16'h3F80}});
      req_valid = 4'b0010;
      #1 chk("t4_ready", 64'(req_ready), 64'h2);
      tick();
      req_valid = '0;
      chk("t4_op", 64'(t_op), 64'd3);
      chk("t4_acc", t_acc, {4{16'h3F80}});
      tick();
      t_done = 1'b1; t_rd = {4{16'h40A0}};
      tick();
      t_done = 1'b0;
      chk("t4_rsp_valid", 64'(rsp_valid), 64'h2);
      chk("t4_rsp_data", rsp_data, 64'h40A040A040A040A0);
      chk("t4_rsp_err", 64'(rsp_err), 64'h0);
      chk("t4_op_count", 64'(op_count), 64'd6);
      t_done = 1'b1; t_rd = 64'hDEAD;
      tick();
      t_done = 1'b0;
      chk("t4_spur_rsp", 64'(rsp_valid), 64'h0);
      chk("t4_spur_busy", 64'(busy), 64'h0);
      tick();
      chk("t4_spur_rsp2", 64'(rsp_valid), 64'h0);
      chk("t4_spur_count", 64'(op_count), 64'd6);
      chk("t4_spur_data", rsp_data, 64'h40A040A040A040A0);

      // 6: done in the ISSUE cycle is ignored (ptr is 2, requester 3 wins)
      set_req(3, 3'd1, 64'h1111, 64'h2222, 64'h0);
      req_valid = 4'b1000;
      #1 chk("t6_ready", 64'(req_ready), 64'h8);
      tick();
      req_valid = '0;
      chk("t6_start", 64'(t_start), 64'h1);
      t_done = 1'b1; t_rd = 64'hBAD0;
      tick();
      t_done = 1'b0;
      chk("t6_early_rsp", 64'(rsp_valid), 64'h0);
      chk("t6_busy", 64'(busy), 64'h1);
      tick();
      chk("t6_still_wait", 64'(busy), 64'h1);
      t_done = 1'b1; t_rd = 64'h600D;
      tick();
      t_done = 1'b0;
      chk("t6_rsp_valid", 64'(rsp_valid), 64'h8);
      chk("t6_rsp_data", rsp_data, 64'h600D);
      chk("t6_op_count", 64'(op_count), 64'd7);
      tick();
      chk("t6_single_rsp", 64'(rsp_valid), 64'h0);

      // 5: reset during WAIT, then arbitration restarts at index 0
      set_req(2, 3'd0, 64'h3333, 64'h4444, 64'h0);
      req_valid = 4'b0100;
      #1 chk("t5_ready", 64'(req_ready), 64'h4);
      tick();
      req_valid = '0;
      tick();
      chk("t5_in_wait", 64'(busy), 64'h1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", 64'(busy), 64'h0);
      chk("t5_rst_count", 64'(op_count), 64'h0);
      chk("t5_rst_t_a", t_a, 64'h0);
      chk("t5_rst_data", rsp_data, 64'h0);
      chk("t5_rst_start", 64'(t_start), 64'h0);
      tick();
      rst_n = 1'b1;
      set_req(1, 3'd4, 64'h7777, 64'h0, 64'h0);
      set_req(3, 3'd4, 64'h8888, 64'h0, 64'h0);
      req_valid = 4'b1010;
      #1 chk("t5_ready_ptr0", 64'(req_ready), 64'h2);
      tick();
      req_valid = '0;
      chk("t5_t_a", t_a, 64'h7777);
      tick();
      t_done = 1'b1; t_rd = 64'h5555;
      tick();
      t_done = 1'b0;
      chk("t5_rsp_valid", 64'(rsp_valid), 64'h2);
      chk("t5_rsp_data", rsp_data, 64'h5555);
      chk("t5_op_count", 64'(op_count), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
